// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default pixel width, unsigned pixel max helper,
// and the max-pool row-phase state type.
package cnn_pkg;

   localparam int PIX_W_DEF = 8;

   // Row phase of the 2x2 pooler: top row, bottom row, or trailing odd row.
   typedef enum logic [1:0] {
      S_EVEN = 2'd0,
      S_ODD  = 2'd1,
      S_DROP = 2'd2
   } pool_state_t;

   function automatic logic [PIX_W_DEF-1:0] max_u(input logic [PIX_W_DEF-1:0] a,
                                                  input logic [PIX_W_DEF-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Row buffer for the 2x2 pooler: holds one horizontal pair-max per window
// column between the top and bottom rows of a window pair.
// Synchronous write, combinational read (maps to distributed RAM).
// Ports:
//   clk      - system clock
//   wr_en    - write strobe
//   wr_addr  - write entry
//   wr_data  - write data
//   rd_addr  - read entry
//   rd_data  - read data (combinational)
module pool_row_buf #(
   parameter int DEPTH = 13,
   parameter int PIX_W = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [PIX_W-1:0] rd_data
);

   // Not reset: each entry is written in an even row before the odd row reads it.
   logic [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster-ordered feature map.
// Accepts every valid pixel (no backpressure); invalid cycles freeze state.
// Odd trailing column/row are counted and discarded.
// Ports:
//   clk            - system clock
//   rst_n          - synchronous active-low reset
//   pixel_in       - input pixel, unsigned
//   pixel_in_valid - pixel_in valid this cycle
//   pool_out       - pooled pixel, held while pool_valid is low
//   pool_valid     - one-cycle pulse, pool_out valid
//   frame_done     - one-cycle pulse after the frame's last pixel is accepted
module maxpool_2x2_stream
   import cnn_pkg::*;
#(
   parameter int IMG_W = 26,
   parameter int IMG_H = 26,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             pixel_in_valid,
   output logic [PIX_W-1:0] pool_out,
   output logic             pool_valid,
   output logic             frame_done
);

   localparam int  BUF_D = IMG_W / 2;
   localparam int  AW    = (BUF_D > 1) ? $clog2(BUF_D) : 1;
   localparam int  CW    = $clog2(IMG_W);
   localparam int  RW    = $clog2(IMG_H);
   localparam bit  H_ODD = (IMG_H % 2) == 1;

   pool_state_t      state, state_nxt;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [PIX_W-1:0] hold_reg;
   logic [PIX_W-1:0] buf_rd;
   logic             col_last, row_last, buf_wr;
   logic [AW-1:0]    buf_addr;

   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   assign buf_addr = AW'(col >> 1);
   // Odd columns close a horizontal pair; an odd-width trailing column is
   // even-indexed, so it never writes or emits.
   assign buf_wr   = pixel_in_valid && (state == S_EVEN) && col[0];

   pool_row_buf #(.DEPTH(BUF_D), .PIX_W(PIX_W), .AW(AW)) u_row_buf (
      .clk     (clk),
      .wr_en   (buf_wr),
      .wr_addr (buf_addr),
      .wr_data (max_u(hold_reg, pixel_in)),
      .rd_addr (buf_addr),
      .rd_data (buf_rd)
   );

   always_comb begin
      state_nxt = state;
      if (pixel_in_valid && col_last) begin
         case (state)
            S_EVEN:  state_nxt = row_last ? S_EVEN : S_ODD;
            // Next row is the unpaired last row of an odd-height frame.
            S_ODD:   state_nxt = (H_ODD && !row_last && row == RW'(IMG_H - 2)) ? S_DROP : S_EVEN;
            default: state_nxt = S_EVEN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_EVEN;
         col        <= '0;
         row        <= '0;
         pool_out   <= '0;
         pool_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         pool_valid <= 1'b0;
         frame_done <= 1'b0;
         if (pixel_in_valid) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (state == S_ODD && col[0]) begin
               pool_out   <= max_u(buf_rd, max_u(hold_reg, pixel_in));
               pool_valid <= 1'b1;
            end
            if (col_last && row_last) frame_done <= 1'b1;
         end
      end
   end

   // Left pixel of the current horizontal pair; don't-care outside a pair.
   always_ff @(posedge clk) begin
      if (pixel_in_valid && !col[0]) hold_reg <= pixel_in;
   end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
module tb_maxpool_2x2_stream;

   typedef struct {
      logic [7:0] v;
      time        t;
   } ev_t;

   logic       clk;
   logic       rst44, rst53;
   logic [7:0] pixel_in;
   logic       pixel_in_valid;
   logic [7:0] out44, out53;
   logic       pv44, pv53, fd44, fd53;

   int n_chk = 0;
   int n_err = 0;

   int  frame_pix[$];
   time acc_t[$];
   ev_t got44[$], got53[$], exp_q[$];
   time fdt44[$], fdt53[$], exp_fd[$];

   maxpool_2x2_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut44 (
      .clk(clk), .rst_n(rst44), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .pool_out(out44), .pool_valid(pv44), .frame_done(fd44));

   maxpool_2x2_stream #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) u_dut53 (
      .clk(clk), .rst_n(rst53), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .pool_out(out53), .pool_valid(pv53), .frame_done(fd53));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (pv44) got44.push_back('{out44, $time});
      if (fd44) fdt44.push_back($time);
      if (pv53) got53.push_back('{out53, $time});
      if (fd53) fdt53.push_back($time);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_pix(input int p, input int maxgap);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) begin
         @(negedge clk);
         pixel_in_valid = 1'b0;
         pixel_in       = 8'($urandom);
         @(posedge clk);
      end
      @(negedge clk);
      pixel_in_valid = 1'b1;
      pixel_in       = 8'(p);
      @(posedge clk);
      frame_pix.push_back(p);
      acc_t.push_back($time);
   endtask

   task automatic idle();
      @(negedge clk);
      pixel_in_valid = 1'b0;
   endtask

   // mode 0: 1..w*h, 1: random, 2: window0 = {255,0,0,254}, rest 0
   task automatic send_frame(input int w, input int h, input int mode, input int maxgap);
      for (int i = 0; i < w * h; i++) begin
         int p;
         case (mode)
            0:       p = i + 1;
            1:       p = int'($urandom_range(255, 0));
            default: p = (i == 0) ? 255 : (i == w + 1) ? 254 : 0;
         endcase
         send_pix(p, maxgap);
      end
   endtask

   // Reference: every complete 2x2 window, raster order; each result is seen
   // on the falling edge after the window's bottom-right pixel is accepted.
   task automatic model(input int w, input int h, input int base);
      for (int r = 0; r < h / 2; r++) begin
         for (int c = 0; c < w / 2; c++) begin
            int i0, m;
            i0 = base + 2 * r * w + 2 * c;
            m  = frame_pix[i0];
            if (frame_pix[i0 + 1] > m)     m = frame_pix[i0 + 1];
            if (frame_pix[i0 + w] > m)     m = frame_pix[i0 + w];
            if (frame_pix[i0 + w + 1] > m) m = frame_pix[i0 + w + 1];
            exp_q.push_back('{8'(m), acc_t[i0 + w + 1] + 5});
         end
      end
      exp_fd.push_back(acc_t[base + w * h - 1] + 5);
   endtask

   task automatic compare(input bit sel, input string name, input bit do_hold);
      ev_t g[$];
      time f[$];
      repeat (4) @(negedge clk);
      if (sel) begin g = got53; f = fdt53; end
      else     begin g = got44; f = fdt44; end
      chk({name, " out_count"}, 64'(g.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < g.size()) begin
            chk($sformatf("%s out[%0d] value", name, i), 64'(g[i].v), 64'(exp_q[i].v));
            chk($sformatf("%s out[%0d] time", name, i), 64'(g[i].t), 64'(exp_q[i].t));
         end
      end
      chk({name, " frame_done_count"}, 64'(f.size()), 64'(exp_fd.size()));
      for (int i = 0; i < exp_fd.size(); i++) begin
         if (i < f.size()) chk($sformatf("%s frame_done[%0d] time", name, i), 64'(f[i]), 64'(exp_fd[i]));
      end
      if (do_hold && exp_q.size() > 0)
         chk({name, " pool_out_hold"}, 64'(sel ? out53 : out44), 64'(exp_q[$].v));
      got44.delete(); got53.delete(); fdt44.delete(); fdt53.delete();
      exp_q.delete(); exp_fd.delete(); frame_pix.delete(); acc_t.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pool_out44"}, 64'(out44), 64'd0);
      chk({tag, " pool_valid44"}, 64'(pv44), 64'd0);
      chk({tag, " frame_done44"}, 64'(fd44), 64'd0);
   endtask

   initial begin
      pixel_in_valid = 1'b0;
      pixel_in       = 8'd0;
      rst44          = 1'b0;
      rst53          = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      chk("reset pool_out53", 64'(out53), 64'd0);
      chk("reset pool_valid53", 64'(pv53), 64'd0);
      chk("reset frame_done53", 64'(fd53), 64'd0);
      rst44 = 1'b1;

      // 4x4 sequential, back-to-back
      send_frame(4, 4, 0, 0); idle();
      model(4, 4, 0);
      compare(1'b0, "seq44", 1'b1);

      // 4x4 sequential with random gaps
      send_frame(4, 4, 0, 3); idle();
      model(4, 4, 0);
      compare(1'b0, "gap44", 1'b1);

      // 5x3: trailing column and row dropped
      @(negedge clk); rst44 = 1'b0; rst53 = 1'b1;
      send_frame(5, 3, 0, 0); idle();
      model(5, 3, 0);
      compare(1'b1, "seq53", 1'b1);
      for (int k = 0; k < 3; k++) begin
         send_frame(5, 3, 1, 2); idle();
         model(5, 3, 0);
         compare(1'b1, $sformatf("rnd53_%0d", k), 1'b1);
      end

      // Unsigned compare at extremes
      @(negedge clk); rst53 = 1'b0; rst44 = 1'b1;
      send_frame(4, 4, 2, 0); idle();
      model(4, 4, 0);
      compare(1'b0, "unsigned44", 1'b1);

      // Two frames back-to-back, no bubble
      send_frame(4, 4, 0, 0);
      send_frame(4, 4, 0, 0); idle();
      model(4, 4, 0);
      model(4, 4, 16);
      compare(1'b0, "twoframe44", 1'b1);

      // Random frames with gaps
      for (int k = 0; k < 4; k++) begin
         send_frame(4, 4, 1, 3); idle();
         model(4, 4, 0);
         compare(1'b0, $sformatf("rnd44_%0d", k), 1'b1);
      end

      // Reset after pixel 7: only the window completed by pixel 6 was emitted
      for (int i = 1; i <= 7; i++) send_pix(i, 0);
      @(negedge clk);
      pixel_in_valid = 1'b0;
      rst44          = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset("midreset");
      rst44 = 1'b1;
      exp_q.push_back('{8'd6, acc_t[5] + 5});
      compare(1'b0, "aborted44", 1'b0);
      send_frame(4, 4, 0, 0); idle();
      model(4, 4, 0);
      compare(1'b0, "postreset44", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
